updn_counter_param: RTL and testbench

- Parametrised successor to the team's fixed 16-bit up/down counter: configurable width, programmable step, runtime lower/upper limits, wrap or saturate mode, terminal-count pulse and sticky overflow/underflow flags.
- Used as a generic event/timer counter in subsystem datapaths.
- Verified with a bound SVA property module, as for the original counter.

---
 rtl/updn_counter_pkg.sv | 18 +
 rtl/updn_counter_param_property.sv | 27 ++
 rtl/updn_prescaler.sv | 38 +++
 rtl/updn_counter_param.sv | 129 ++++++++++++
 tb/tb_updn_counter_param.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/updn_counter_pkg.sv
// Shared types and default sizes for the parametrised up/down counter.
package updn_counter_pkg;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } count_dir_e;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } limit_mode_e;

    localparam int DEF_WIDTH    = 16;
    localparam int DEF_STEP_W   = 4;
    localparam int DEF_PRESCALE = 4;

endpackage

// File: rtl/updn_counter_param_property.sv
// Invariants of updn_counter_param, bound onto the top.
module updn_counter_param_property #(
    parameter int WIDTH = 16
) (
    input logic             clk,
    input logic             rst,
    input logic             ld_cnt,
    input logic [WIDTH-1:0] lim_lo,
    input logic [WIDTH-1:0] lim_hi,
    input logic [WIDTH-1:0] data_out,
    input logic             tc,
    input logic             ovf,
    input logic             udf,
    input logic             cfg_err
);

    a_cfg_err: assert property (@(posedge clk) cfg_err == (lim_lo > lim_hi));

    a_reset: assert property (@(posedge clk)
        rst |=> (data_out == '0 && !tc && !ovf && !udf));

    // A terminal count is always accompanied by the flag it sets on the same edge.
    a_tc_flag: assert property (@(posedge clk) disable iff (rst) tc |-> (ovf || udf));

    a_load_no_tc: assert property (@(posedge clk) (!rst && !ld_cnt) |=> !tc);

endmodule

// File: rtl/updn_prescaler.sv
// Divides count advances by PRESCALE; tick marks the advance that lets the counter act.
module updn_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic adv,
    output logic tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          at_last;

    assign at_last = (cnt_q == LAST);
    assign tick    = adv & at_last;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (adv) begin
            cnt_d = at_last ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/updn_counter_param.sv
// Parametrised up/down counter with runtime limits, wrap/saturate, tc pulse and sticky flags.
// Optional prescaler is compiled in with `define UPDN_COUNTER_PRESCALE_EN.
module updn_counter_param
    import updn_counter_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int STEP_W   = DEF_STEP_W,
    parameter int PRESCALE = DEF_PRESCALE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  data_in,
    input  logic              ld_cnt,
    input  logic              updn_cnt,
    input  logic              count_enb,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  lim_lo,
    input  logic [WIDTH-1:0]  lim_hi,
    input  logic              sat_mode,
    input  logic              clr_flags,
    output logic [WIDTH-1:0]  data_out,
    output logic              tc,
    output logic              ovf,
    output logic              udf,
    output logic              cfg_err
);

    localparam int XW = WIDTH + 1;

    logic [WIDTH-1:0] data_q, data_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    count_dir_e       dir;
    limit_mode_e      mode;
    logic             count_adv;
    logic             count_fire;
    logic [WIDTH-1:0] ld_lo_clamped;
    logic [WIDTH-1:0] ld_val;
    logic [XW-1:0]    d_x, lo_x, hi_x, step_x;
    logic [XW-1:0]    room_up, room_dn;

    assign dir     = count_dir_e'(updn_cnt);
    assign mode    = limit_mode_e'(sat_mode);
    assign cfg_err = (lim_lo > lim_hi);

    assign count_adv = count_enb & ld_cnt & (step != '0) & ~cfg_err;

`ifdef UPDN_COUNTER_PRESCALE_EN
    updn_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (~ld_cnt),
        .adv  (count_adv),
        .tick (count_fire)
    );
`else
    logic unused_prescale;
    assign unused_prescale = (PRESCALE > 0);
    assign count_fire      = count_adv;
`endif

    // Lower clamp first, then upper: with inverted limits a load always lands on lim_hi.
    assign ld_lo_clamped = (data_in < lim_lo) ? lim_lo : data_in;
    assign ld_val        = (ld_lo_clamped > lim_hi) ? lim_hi : ld_lo_clamped;

    // Headroom is computed one bit wider so a step can never wrap past 2^WIDTH.
    assign d_x     = XW'(data_q);
    assign lo_x    = XW'(lim_lo);
    assign hi_x    = XW'(lim_hi);
    assign step_x  = XW'(step);
    assign room_up = hi_x - d_x;
    assign room_dn = d_x - lo_x;

    always_comb begin
        data_d = data_q;
        tc_d   = 1'b0;
        ovf_d  = ovf_q & ~clr_flags;
        udf_d  = udf_q & ~clr_flags;
        if (!ld_cnt) begin
            data_d = ld_val;
        end else if (count_fire) begin
            if (data_q < lim_lo) begin
                data_d = lim_lo;
            end else if (data_q > lim_hi) begin
                data_d = lim_hi;
            end else if (dir == DIR_UP) begin
                if (room_up >= step_x) begin
                    data_d = WIDTH'(d_x + step_x);
                end else begin
                    ovf_d  = 1'b1;
                    tc_d   = 1'b1;
                    data_d = (mode == MODE_SAT) ? lim_hi : lim_lo;
                end
            end else begin
                if (room_dn >= step_x) begin
                    data_d = WIDTH'(d_x - step_x);
                end else begin
                    udf_d  = 1'b1;
                    tc_d   = 1'b1;
                    data_d = (mode == MODE_SAT) ? lim_lo : lim_hi;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            tc_q   <= 1'b0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            tc_q   <= tc_d;
            ovf_q  <= ovf_d;
            udf_q  <= udf_d;
        end
    end

    assign data_out = data_q;
    assign tc       = tc_q;
    assign ovf      = ovf_q;
    assign udf      = udf_q;

endmodule

// File: tb/tb_updn_counter_param.sv
// Self-checking bench for updn_counter_param: directed scenarios plus random traffic vs a behavioural model.
module tb_updn_counter_param;

    localparam int WIDTH    = 16;
    localparam int STEP_W   = 4;
    localparam int PRESCALE = 4;
`ifdef UPDN_COUNTER_PRESCALE_EN
    localparam int NP = PRESCALE;
`else
    localparam int NP = 1;
`endif
    localparam int MAXV = (1 << WIDTH) - 1;

    logic              clk;
    logic              rst;
    logic [WIDTH-1:0]  data_in;
    logic              ld_cnt;
    logic              updn_cnt;
    logic              count_enb;
    logic [STEP_W-1:0] step;
    logic [WIDTH-1:0]  lim_lo;
    logic [WIDTH-1:0]  lim_hi;
    logic              sat_mode;
    logic              clr_flags;
    logic [WIDTH-1:0]  data_out;
    logic              tc;
    logic              ovf;
    logic              udf;
    logic              cfg_err;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 0;

    updn_counter_param #(
        .WIDTH    (WIDTH),
        .STEP_W   (STEP_W),
        .PRESCALE (PRESCALE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .ld_cnt    (ld_cnt),
        .updn_cnt  (updn_cnt),
        .count_enb (count_enb),
        .step      (step),
        .lim_lo    (lim_lo),
        .lim_hi    (lim_hi),
        .sat_mode  (sat_mode),
        .clr_flags (clr_flags),
        .data_out  (data_out),
        .tc        (tc),
        .ovf       (ovf),
        .udf       (udf),
        .cfg_err   (cfg_err)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int m_data = 0;
    int m_tc   = 0;
    int m_ovf  = 0;
    int m_udf  = 0;
    int m_pre  = 0;

    always @(posedge clk) begin : model
        int lo, hi, st, d;
        bit fire;
        lo = int'(lim_lo);
        hi = int'(lim_hi);
        st = int'(step);
        d  = m_data;
        if (rst) begin
            m_data = 0; m_tc = 0; m_ovf = 0; m_udf = 0; m_pre = 0;
        end else begin
            m_tc = 0;
            if (clr_flags) begin
                m_ovf = 0;
                m_udf = 0;
            end
            if (!ld_cnt) begin
                d = int'(data_in);
                if (d < lo) d = lo;
                if (d > hi) d = hi;
                m_pre = 0;
            end else if (count_enb && st != 0 && !(lo > hi)) begin
                fire = 1;
                if (NP > 1) begin
                    if (m_pre == NP - 1) m_pre = 0;
                    else begin
                        m_pre = m_pre + 1;
                        fire = 0;
                    end
                end
                if (fire) begin
                    if (d < lo) d = lo;
                    else if (d > hi) d = hi;
                    else if (updn_cnt) begin
                        if (hi - d >= st) d = d + st;
                        else begin
                            m_ovf = 1; m_tc = 1;
                            d = sat_mode ? hi : lo;
                        end
                    end else begin
                        if (d - lo >= st) d = d - st;
                        else begin
                            m_udf = 1; m_tc = 1;
                            d = sat_mode ? lo : hi;
                        end
                    end
                end
            end
            m_data = d;
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("data_out", longint'(data_out), longint'(m_data));
            chk("tc", longint'(tc), longint'(m_tc));
            chk("ovf", longint'(ovf), longint'(m_ovf));
            chk("udf", longint'(udf), longint'(m_udf));
            chk("cfg_err", longint'(cfg_err), longint'(lim_lo > lim_hi));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int v, input int lo, input int hi);
        lim_lo    = WIDTH'(lo);
        lim_hi    = WIDTH'(hi);
        data_in   = WIDTH'(v);
        count_enb = 1'b0;
        ld_cnt    = 1'b0;
        cycle();
        ld_cnt    = 1'b1;
    endtask

    task automatic count_once(input bit up, input int st, input bit sat);
        updn_cnt  = up;
        step      = STEP_W'(st);
        sat_mode  = sat;
        count_enb = 1'b1;
        repeat (NP) cycle();
        count_enb = 1'b0;
    endtask

    task automatic random_cycle();
        rst       = ($urandom_range(0, 63) == 0);
        ld_cnt    = ($urandom_range(0, 7) != 0);
        count_enb = ($urandom_range(0, 3) != 0);
        updn_cnt  = 1'($urandom_range(0, 1));
        step      = STEP_W'($urandom_range(0, 15));
        sat_mode  = 1'($urandom_range(0, 1));
        clr_flags = ($urandom_range(0, 9) == 0);
        if ($urandom_range(0, 15) == 0) begin
            case ($urandom_range(0, 3))
                0: begin lim_lo = '0; lim_hi = WIDTH'(MAXV); end
                1: begin
                    lim_lo = WIDTH'($urandom_range(0, 100));
                    lim_hi = lim_lo + WIDTH'($urandom_range(0, 60));
                end
                2: begin
                    lim_lo = WIDTH'($urandom_range(0, 200));
                    lim_hi = WIDTH'($urandom_range(0, 200));
                end
                default: begin
                    lim_lo = WIDTH'($urandom_range(MAXV - 40, MAXV));
                    lim_hi = WIDTH'(MAXV);
                end
            endcase
        end
        if ($urandom_range(0, 1) == 0) data_in = WIDTH'($urandom_range(0, MAXV));
        else data_in = lim_hi - WIDTH'($urandom_range(0, 8));
        cycle();
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        rst = 1'b1; data_in = '0; ld_cnt = 1'b1; updn_cnt = 1'b1; count_enb = 1'b0;
        step = '0; lim_lo = '0; lim_hi = 16'd100; sat_mode = 1'b0; clr_flags = 1'b0;
        cycle();
        cycle();
        chk_en = 1'b1;
        chk("reset_data", longint'(data_out), 0);
        chk("reset_flags", longint'({tc, ovf, udf}), 0);
        rst = 1'b0;

        load(7, 0, 100);
        chk("load_7", longint'(data_out), 7);

        // wrap up across lim_hi
        load(18, 5, 20);
        count_once(1'b1, 3, 1'b0);
        chk("wrap_data", longint'(data_out), 5);
        chk("wrap_tc", longint'(tc), 1);
        chk("wrap_ovf", longint'(ovf), 1);
        count_once(1'b1, 3, 1'b0);
        chk("wrap_next_data", longint'(data_out), 8);
        chk("wrap_next_tc", longint'(tc), 0);

        clr_flags = 1'b1; cycle(); clr_flags = 1'b0;
        chk("clr_ovf", longint'(ovf), 0);

        // saturate down, then re-pulse while pinned at the limit
        load(6, 5, 20);
        count_once(1'b0, 4, 1'b1);
        chk("sat_data", longint'(data_out), 5);
        chk("sat_udf", longint'(udf), 1);
        chk("sat_tc", longint'(tc), 1);
        count_once(1'b0, 4, 1'b1);
        chk("sat_hold_data", longint'(data_out), 5);
        chk("sat_retc", longint'(tc), 1);
        cycle();
        chk("sat_tc_drop", longint'(tc), 0);

        // load clamp and inverted limits
        load(54, 0, 40);
        chk("clamp_40", longint'(data_out), 40);
        lim_lo = 16'd50; lim_hi = 16'd10;
        updn_cnt = 1'b1; step = 4'd1; count_enb = 1'b1;
        #1;
        chk("cfg_err_set", longint'(cfg_err), 1);
        repeat (NP + 1) cycle();
        count_enb = 1'b0;
        chk("cfg_hold", longint'(data_out), 40);
        load(30, 50, 10);
        chk("cfg_load_hi", longint'(data_out), 10);

        // clear racing a crossing: the crossing wins
        clr_flags = 1'b1; cycle();
        load(99, 0, 100);
        count_once(1'b1, 3, 1'b0);
        chk("race_ovf", longint'(ovf), 1);
        chk("race_data", longint'(data_out), 0);
        cycle();
        clr_flags = 1'b0;
        chk("race_clear", longint'(ovf), 0);

        // exact landing on a limit is not a crossing
        load(17, 5, 20);
        count_once(1'b1, 3, 1'b0);
        chk("land_hi", longint'(data_out), 20);
        chk("land_tc", longint'(tc), 0);

        // top of the full range must not wrap through zero
        load(MAXV - 1, 0, MAXV);
        count_once(1'b1, 5, 1'b1);
        chk("full_sat", longint'(data_out), MAXV);
        chk("full_ovf", longint'(ovf), 1);

        // runtime limit move: next step only clamps
        clr_flags = 1'b1; cycle(); clr_flags = 1'b0;
        load(10, 5, 20);
        lim_lo = 16'd12;
        count_once(1'b1, 2, 1'b0);
        chk("reclamp_data", longint'(data_out), 12);
        chk("reclamp_quiet", longint'({tc, ovf, udf}), 0);

`ifdef UPDN_COUNTER_PRESCALE_EN
        load(0, 0, 100);
        updn_cnt = 1'b1; step = 4'd1; count_enb = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            cycle();
            chk("prescale_run", longint'(data_out), longint'(i / PRESCALE));
        end
        count_enb = 1'b0;
`endif

        repeat (600) random_cycle();
        rst = 1'b0; ld_cnt = 1'b1; count_enb = 1'b0; clr_flags = 1'b0;
        cycle();
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

bind updn_counter_param updn_counter_param_property #(.WIDTH(WIDTH)) u_prop (
    .clk      (clk),
    .rst      (rst),
    .ld_cnt   (ld_cnt),
    .lim_lo   (lim_lo),
    .lim_hi   (lim_hi),
    .data_out (data_out),
    .tc       (tc),
    .ovf      (ovf),
    .udf      (udf),
    .cfg_err  (cfg_err)
);
